psr_flag_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 38 +++
 rtl/psr_cond_eval.sv | 35 +++
 rtl/psr_flag_unit.sv | 120 ++++++++++++
 tb/tb_psr_flag_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and branch condition codes.
// Used by the PSR stage, the condition evaluator and the branch unit.
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ASHU = 8'h86;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/psr_cond_eval.sv
// Combinational branch/jump condition evaluation of a 4-bit code against a PSR value.
module psr_cond_eval
  import alu_pkg::*;
#(
  parameter int FLAG_W = 5
) (
  input  logic [FLAG_W-1:0] psr,
  input  logic [3:0]        cond,
  output logic              is_true
);

  always_comb begin
    is_true = 1'b0;
    case (cond)
      COND_EQ: is_true = psr[FLAG_Z];
      COND_NE: is_true = !psr[FLAG_Z];
      COND_CS: is_true = psr[FLAG_C];
      COND_CC: is_true = !psr[FLAG_C];
      COND_HI: is_true = psr[FLAG_L];
      COND_LS: is_true = !psr[FLAG_L];
      COND_GT: is_true = psr[FLAG_N];
      COND_LE: is_true = !psr[FLAG_N];
      COND_FS: is_true = psr[FLAG_F];
      COND_FC: is_true = !psr[FLAG_F];
      COND_LO: is_true = !psr[FLAG_L] && !psr[FLAG_Z];
      COND_HS: is_true = psr[FLAG_L] || psr[FLAG_Z];
      COND_LT: is_true = !psr[FLAG_N] && !psr[FLAG_Z];
      COND_GE: is_true = psr[FLAG_N] || psr[FLAG_Z];
      COND_UC: is_true = 1'b1;
      COND_NV: is_true = 1'b0;
      default: is_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_flag_unit.sv
// Processor status register stage behind the ALU, with registered condition evaluation.
// Optional save/restore shadow register enabled by defining PSR_SHADOW_EN.
module psr_flag_unit
  import alu_pkg::*;
#(
  parameter int                FLAG_W    = 5,
  parameter logic [FLAG_W-1:0] RESET_PSR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        alu_op,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flag_we,
  input  logic              stall,
  input  logic              psr_wr,
  input  logic [FLAG_W-1:0] psr_wdata,
  input  logic              cond_valid,
  input  logic [3:0]        cond,
`ifdef PSR_SHADOW_EN
  input  logic              psr_save,
  input  logic              psr_restore,
`endif
  output logic [FLAG_W-1:0] psr,
  output logic              carry_out,
  output logic              cond_true,
  output logic              cond_done
);

  logic [FLAG_W-1:0] psr_reg;
  logic [FLAG_W-1:0] psr_next;
  logic [FLAG_W-1:0] upd_mask;
  logic [FLAG_W-1:0] alu_merged;
  logic              cond_true_reg;
  logic              cond_done_reg;
  logic              fwd_true;

`ifdef PSR_SHADOW_EN
  logic [FLAG_W-1:0] shadow_reg;
`endif

  always_comb begin
    upd_mask = '0;
    case (alu_op)
      OP_ADD: begin
        upd_mask[FLAG_C] = 1'b1;
        upd_mask[FLAG_Z] = 1'b1;
        upd_mask[FLAG_N] = 1'b1;
      end
      OP_SUB: begin
        upd_mask[FLAG_Z] = 1'b1;
        upd_mask[FLAG_N] = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ASHU: begin
        upd_mask[FLAG_Z] = 1'b1;
      end
      OP_CMP: begin
        upd_mask[FLAG_L] = 1'b1;
        upd_mask[FLAG_F] = 1'b1;
        upd_mask[FLAG_Z] = 1'b1;
        upd_mask[FLAG_N] = 1'b1;
      end
      default: upd_mask = '0;
    endcase
  end

  // A per-bit select keeps don't-care ALU bits (even X) out of the held bits.
  generate
    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_merge
      assign alu_merged[gi] = upd_mask[gi] ? alu_flags[gi] : psr_reg[gi];
    end
  endgenerate

  // Later assignments take precedence: restore > software write > ALU update.
  always_comb begin
    psr_next = psr_reg;
    if (flag_we) psr_next = alu_merged;
    if (psr_wr)  psr_next = psr_wdata;
`ifdef PSR_SHADOW_EN
    if (psr_restore) psr_next = shadow_reg;
`endif
  end

  // Evaluating on psr_next forwards a same-cycle flag update into the condition.
  psr_cond_eval #(
    .FLAG_W (FLAG_W)
  ) u_cond_eval (
    .psr     (psr_next),
    .cond    (cond),
    .is_true (fwd_true)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      psr_reg       <= RESET_PSR;
      cond_true_reg <= 1'b0;
      cond_done_reg <= 1'b0;
    end else if (!stall) begin
      psr_reg       <= psr_next;
      cond_done_reg <= cond_valid;
      if (cond_valid) cond_true_reg <= fwd_true;
    end
  end

`ifdef PSR_SHADOW_EN
  // Saves the pre-update PSR, so save+restore in one cycle swaps the two.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= RESET_PSR;
    end else if (!stall && psr_save) begin
      shadow_reg <= psr_reg;
    end
  end
`endif

  assign psr       = psr_reg;
  assign carry_out = psr_reg[FLAG_C];
  assign cond_true = cond_true_reg;
  assign cond_done = cond_done_reg;

endmodule

// File: tb/tb_psr_flag_unit.sv
// Self-checking bench for psr_flag_unit: directed vector table, corner sequences and
// randomized traffic against a flag-rule reference model (shadow tests with PSR_SHADOW_EN).
module tb_psr_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_op;
  logic [4:0] alu_flags;
  logic       flag_we;
  logic       stall;
  logic       psr_wr;
  logic [4:0] psr_wdata;
  logic       cond_valid;
  logic [3:0] cond;
`ifdef PSR_SHADOW_EN
  logic       psr_save;
  logic       psr_restore;
`endif
  logic [4:0] psr;
  logic       carry_out;
  logic       cond_true;
  logic       cond_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0] m_psr;
  logic [4:0] m_sh;
  logic       m_ct;
  logic       m_cd;

  always #5 clk = ~clk;

  psr_flag_unit dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .alu_flags  (alu_flags),
    .flag_we    (flag_we),
    .stall      (stall),
    .psr_wr     (psr_wr),
    .psr_wdata  (psr_wdata),
    .cond_valid (cond_valid),
    .cond       (cond),
`ifdef PSR_SHADOW_EN
    .psr_save   (psr_save),
    .psr_restore(psr_restore),
`endif
    .psr        (psr),
    .carry_out  (carry_out),
    .cond_true  (cond_true),
    .cond_done  (cond_done)
  );

  // Bits each opcode defines, as a mask in N Z F L C order.
  function automatic logic [4:0] ref_mask(input logic [7:0] op);
    case (op)
      8'h05:                         return 5'b11001;
      8'h09:                         return 5'b11000;
      8'h01, 8'h02, 8'h03, 8'h84, 8'h86: return 5'b01000;
      8'h0B:                         return 5'b11110;
      default:                       return 5'b00000;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] c);
    logic cf, lf, ff, zf, nf;
    {nf, zf, ff, lf, cf} = p;
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [4:0] nxt;
    logic [4:0] msk;
    logic [4:0] new_sh;
    if (reset) begin
      m_psr = 5'b00000;
      m_sh  = 5'b00000;
      m_ct  = 1'b0;
      m_cd  = 1'b0;
    end else if (!stall) begin
      msk    = ref_mask(alu_op);
      new_sh = m_sh;
      nxt    = m_psr;
`ifdef PSR_SHADOW_EN
      if (psr_save) new_sh = m_psr;
      if (psr_restore) nxt = m_sh;
      else
`endif
      if (psr_wr) nxt = psr_wdata;
      else if (flag_we) nxt = (alu_flags & msk) | (m_psr & ~msk);
      if (cond_valid) m_ct = ref_cond(nxt, cond);
      m_cd  = cond_valid;
      m_psr = nxt;
      m_sh  = new_sh;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    reset      = 1'b0;
    alu_op     = 8'h0D;
    alu_flags  = 5'b00000;
    flag_we    = 1'b0;
    stall      = 1'b0;
    psr_wr     = 1'b0;
    psr_wdata  = 5'b00000;
    cond_valid = 1'b0;
    cond       = 4'd0;
`ifdef PSR_SHADOW_EN
    psr_save    = 1'b0;
    psr_restore = 1'b0;
`endif
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    $display("%0t %s rst=%b op=%h fl=%b we=%b wr=%b st=%b cv=%b cond=%0d -> psr=%b co=%b ct=%b cd=%b",
             $time, tag, reset, alu_op, alu_flags, flag_we, psr_wr, stall, cond_valid, cond,
             psr, carry_out, cond_true, cond_done);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".psr"}, {3'b000, psr}, {3'b000, m_psr});
    chk({tag, ".carry"}, {7'd0, carry_out}, {7'd0, m_psr[0]});
    chk({tag, ".cond_true"}, {7'd0, cond_true}, {7'd0, m_ct});
    chk({tag, ".cond_done"}, {7'd0, cond_done}, {7'd0, m_cd});
  endtask

  typedef struct {
    logic [7:0] op;
    logic [4:0] flags;
    logic       we;
    logic       wr;
    logic [4:0] wdata;
    logic       cv;
    logic [3:0] cnd;
    logic       st;
    logic [4:0] e_psr;
    logic       e_ct;
    logic       e_cd;
  } vec_t;

  vec_t tbl[18];

  initial begin
    //            op     flags      we    wr    wdata     cv    cond   st    psr       ct    cd
    tbl[0]  = '{8'h05, 5'b10xx1, 1'b1, 1'b0, 5'b00000, 1'b0, 4'd0,  1'b0, 5'b10001, 1'b0, 1'b0};
    tbl[1]  = '{8'h0B, 5'b01010, 1'b1, 1'b0, 5'b00000, 1'b0, 4'd0,  1'b0, 5'b01011, 1'b0, 1'b0};
    tbl[2]  = '{8'h02, 5'bx0xxx, 1'b1, 1'b0, 5'b00000, 1'b0, 4'd0,  1'b0, 5'b00011, 1'b0, 1'b0};
    tbl[3]  = '{8'h0D, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 4'd0,  1'b0, 5'b00000, 1'b0, 1'b0};
    tbl[4]  = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 4'd10, 1'b0, 5'b00000, 1'b1, 1'b1};
    tbl[5]  = '{8'h09, 5'b01000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd10, 1'b0, 5'b01000, 1'b0, 1'b1};
    tbl[6]  = '{8'h0B, 5'b00000, 1'b1, 1'b1, 5'b11111, 1'b0, 4'd0,  1'b0, 5'b11111, 1'b0, 1'b0};
    tbl[7]  = '{8'h0D, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 4'd0,  1'b1, 5'b11111, 1'b0, 1'b0};
    tbl[8]  = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 4'd2,  1'b0, 5'b11111, 1'b1, 1'b1};
    tbl[9]  = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 4'd13, 1'b0, 5'b11111, 1'b1, 1'b1};
    tbl[10] = '{8'h0D, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd3,  1'b0, 5'b11111, 1'b0, 1'b1};
    tbl[11] = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0,  1'b0, 5'b11111, 1'b0, 1'b0};
    tbl[12] = '{8'h84, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd1,  1'b0, 5'b10111, 1'b1, 1'b1};
    tbl[13] = '{8'h86, 5'b01000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd0,  1'b0, 5'b11111, 1'b1, 1'b1};
    tbl[14] = '{8'h03, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd12, 1'b0, 5'b10111, 1'b0, 1'b1};
    tbl[15] = '{8'h05, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b1, 4'd14, 1'b0, 5'b00110, 1'b1, 1'b1};
    tbl[16] = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 4'd5,  1'b0, 5'b00110, 1'b0, 1'b1};
    tbl[17] = '{8'h0D, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 4'd8,  1'b0, 5'b00110, 1'b1, 1'b1};

    idle();
    m_psr = 5'b00000;
    m_sh  = 5'b00000;
    m_ct  = 1'b0;
    m_cd  = 1'b0;

    // Reset state
    reset = 1'b1;
    step("reset");
    step("reset");
    chk("reset.psr", {3'b000, psr}, 8'h00);
    chk("reset.cond_true", {7'd0, cond_true}, 8'h00);
    chk("reset.cond_done", {7'd0, cond_done}, 8'h00);
    reset = 1'b0;

    // Directed vector table with hand-derived expectations
    for (int i = 0; i < 18; i++) begin
      idle();
      alu_op     = tbl[i].op;
      alu_flags  = tbl[i].flags;
      flag_we    = tbl[i].we;
      psr_wr     = tbl[i].wr;
      psr_wdata  = tbl[i].wdata;
      cond_valid = tbl[i].cv;
      cond       = tbl[i].cnd;
      stall      = tbl[i].st;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.psr", i), {3'b000, psr}, {3'b000, tbl[i].e_psr});
      chk($sformatf("vec%0d.carry", i), {7'd0, carry_out}, {7'd0, tbl[i].e_psr[0]});
      chk($sformatf("vec%0d.cond_true", i), {7'd0, cond_true}, {7'd0, tbl[i].e_ct});
      chk($sformatf("vec%0d.cond_done", i), {7'd0, cond_done}, {7'd0, tbl[i].e_cd});
    end

    // NV requests every cycle with a stall in cycle 2, then reset mid-stream
    idle();
    cond_valid = 1'b1;
    cond       = 4'd14;
    step("seq.uc");
    chk("seq.uc.cond_true", {7'd0, cond_true}, 8'h01);
    cond = 4'd15;
    step("seq.nv1");
    chk("seq.nv1.cond_done", {7'd0, cond_done}, 8'h01);
    chk("seq.nv1.cond_true", {7'd0, cond_true}, 8'h00);
    stall = 1'b1;
    step("seq.nv2.stall");
    chk("seq.stall.cond_done", {7'd0, cond_done}, 8'h01);
    chk("seq.stall.cond_true", {7'd0, cond_true}, 8'h00);
    stall = 1'b0;
    step("seq.nv3");
    chk("seq.nv3.cond_done", {7'd0, cond_done}, 8'h01);
    step("seq.nv4");
    chk("seq.nv4.cond_done", {7'd0, cond_done}, 8'h01);
    reset  = 1'b1;
    psr_wr = 1'b1;
    psr_wdata = 5'b10101;
    step("seq.reset");
    chk("seq.reset.cond_done", {7'd0, cond_done}, 8'h00);
    chk("seq.reset.psr", {3'b000, psr}, 8'h00);
    idle();
    step("seq.idle");
    chk("seq.drop.cond_done", {7'd0, cond_done}, 8'h00);
    check_model("seq.idle");

`ifdef PSR_SHADOW_EN
    idle();
    psr_wr = 1'b1; psr_wdata = 5'b00101;
    step("sh.wr");
    idle();
    psr_save = 1'b1;
    step("sh.save");
    idle();
    psr_wr = 1'b1; psr_wdata = 5'b11000;
    step("sh.wr2");
    chk("sh.wr2.psr", {3'b000, psr}, 8'h18);
    idle();
    psr_restore = 1'b1;
    psr_wr = 1'b1; psr_wdata = 5'b11111;
    step("sh.restore");
    chk("sh.restore.psr", {3'b000, psr}, 8'h05);
    idle();
    psr_wr = 1'b1; psr_wdata = 5'b01110;
    step("sh.wr3");
    idle();
    psr_save = 1'b1; psr_restore = 1'b1;
    step("sh.swap");
    chk("sh.swap.psr", {3'b000, psr}, 8'h05);
    idle();
    psr_restore = 1'b1;
    step("sh.restore2");
    chk("sh.swap.shadow", {3'b000, psr}, 8'h0E);
    idle();
    stall = 1'b1; psr_restore = 1'b1; psr_save = 1'b1;
    step("sh.stall");
    chk("sh.stall.psr", {3'b000, psr}, 8'h0E);
    check_model("sh.stall");
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ops[10];
      ops = '{8'h01, 8'h02, 8'h03, 8'h84, 8'h05, 8'h86, 8'h09, 8'h0B, 8'h0D, 8'h00};
      idle();
      reset      = ($urandom_range(0, 49) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      alu_op     = ($urandom_range(0, 9) == 9) ? 8'($urandom) : ops[$urandom_range(0, 9)];
      alu_flags  = 5'($urandom);
      flag_we    = ($urandom_range(0, 2) != 0);
      psr_wr     = ($urandom_range(0, 5) == 0);
      psr_wdata  = 5'($urandom);
      cond_valid = ($urandom_range(0, 2) != 0);
      cond       = 4'($urandom);
`ifdef PSR_SHADOW_EN
      psr_save    = ($urandom_range(0, 5) == 0);
      psr_restore = ($urandom_range(0, 5) == 0);
`endif
      step($sformatf("rnd%0d", i));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
